// File: rtl/vect_pkg.sv
// +----------------------------------------------------------------------------+
// | vect_pkg: shared types and constants for the vector dispatch controller.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package vect_pkg;

    localparam int DISP_DATA_WIDTH      = 32;
    localparam int DISP_QUEUE_DEPTH_DEF = 4;
    localparam int DISP_GUARD_W         = 2;

    typedef enum logic [1:0] {
        DISP_IDLE  = 2'd0,
        DISP_GUARD = 2'd1,
        DISP_WAIT  = 2'd2
    } disp_state_t;

    typedef struct packed {
        logic [DISP_DATA_WIDTH-1:0] instr;
        logic [DISP_DATA_WIDTH-1:0] rs1;
        logic [DISP_DATA_WIDTH-1:0] rs2;
    } disp_entry_t;

endpackage

`default_nettype wire

// File: rtl/vinstr_fifo.sv
// +----------------------------------------------------------------------------+
// | vinstr_fifo: synchronous FIFO of dispatch entries, head read from storage.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module vinstr_fifo
    import vect_pkg::*;
#(
    parameter int DEPTH = DISP_QUEUE_DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    input  logic                     push_i,
    input  disp_entry_t              wdata_i,
    input  logic                     pop_i,
    output disp_entry_t              head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    disp_entry_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (count_o == DEPTH[AW:0]);
    assign empty_o = (count_o == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/vec_dispatch_ctrl.sv
// +----------------------------------------------------------------------------+
// | vec_dispatch_ctrl: in-order scalar-to-vector instruction dispatch with a  |
// | held scalar result register. Rev 1.0                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module vec_dispatch_ctrl
    import vect_pkg::*;
#(
    parameter int DATA_WIDTH   = DISP_DATA_WIDTH,
    parameter int QUEUE_DEPTH  = DISP_QUEUE_DEPTH_DEF,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                           clk_i,
    input  logic                           resetn_i,
    input  logic [DATA_WIDTH-1:0]          s_instr_i,
    input  logic [DATA_WIDTH-1:0]          s_rs1_i,
    input  logic [DATA_WIDTH-1:0]          s_rs2_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    output logic [DATA_WIDTH-1:0]          s_rd_o,
    output logic                           s_rd_valid_o,
    input  logic                           s_rd_ack_i,
    output logic [DATA_WIDTH-1:0]          vinstr_o,
    output logic [DATA_WIDTH-1:0]          rs1_o,
    output logic [DATA_WIDTH-1:0]          rs2_o,
    output logic                           vreq_o,
    input  logic                           vready_i,
    input  logic [DATA_WIDTH-1:0]          rd_i,
    input  logic                           rd_wr_en_i,
    output logic                           busy_o,
    output logic [$clog2(QUEUE_DEPTH):0]   q_cnt_o,
    output logic                           rd_ovf_o
);

    disp_state_t               state;
    logic [DISP_GUARD_W-1:0]   guard_cnt;
    disp_entry_t               push_entry;
    disp_entry_t               head;
    logic                      q_full;
    logic                      q_empty;
    logic                      can_issue;
    logic                      pop;

    assign push_entry = '{instr: s_instr_i, rs1: s_rs1_i, rs2: s_rs2_i};
    assign s_ready_o  = !q_full;
    assign busy_o     = (q_cnt_o != '0) || (state != DISP_IDLE);

    vinstr_fifo #(
        .DEPTH    (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push_i   (s_valid_i),
        .wdata_i  (push_entry),
        .pop_i    (pop),
        .head_o   (head),
        .full_o   (q_full),
        .empty_o  (q_empty),
        .count_o  (q_cnt_o)
    );

    // A pending scalar result blocks issue so no instruction can race ahead of an unread rd.
    always_comb begin
        can_issue = !q_empty && !s_rd_valid_o;
        pop       = 1'b0;
        case (state)
            DISP_IDLE: pop = can_issue;
            DISP_WAIT: pop = vready_i && can_issue;
            default:   pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state     <= DISP_IDLE;
            guard_cnt <= '0;
            vreq_o    <= 1'b0;
            vinstr_o  <= '0;
            rs1_o     <= '0;
            rs2_o     <= '0;
        end else begin
            vreq_o <= 1'b0;
            if (pop) begin
                vinstr_o  <= head.instr;
                rs1_o     <= head.rs1;
                rs2_o     <= head.rs2;
                vreq_o    <= 1'b1;
                guard_cnt <= DISP_GUARD_W'(GUARD_CYCLES);
                state     <= DISP_GUARD;
            end else begin
                case (state)
                    DISP_GUARD: begin
                        // vready_i is stale until the core has latched the new instruction.
                        if (guard_cnt <= DISP_GUARD_W'(1)) begin
                            guard_cnt <= '0;
                            state     <= DISP_WAIT;
                        end else begin
                            guard_cnt <= guard_cnt - 1'b1;
                        end
                    end
                    DISP_WAIT: begin
                        if (vready_i) begin
                            state <= DISP_IDLE;
                        end
                    end
                    default: state <= DISP_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            s_rd_o       <= '0;
            s_rd_valid_o <= 1'b0;
            rd_ovf_o     <= 1'b0;
        end else begin
            if (rd_wr_en_i && (!s_rd_valid_o || s_rd_ack_i)) begin
                s_rd_o       <= rd_i;
                s_rd_valid_o <= 1'b1;
            end else if (s_rd_ack_i) begin
                s_rd_valid_o <= 1'b0;
            end
            if (rd_wr_en_i && s_rd_valid_o && !s_rd_ack_i) begin
                rd_ovf_o <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
